// File: rtl/input_conditioner_led.sv
// input_conditioner_led: board UI front end.
// Debounces 8 slide switches into clean levels and 4 push buttons into
// single-cycle press pulses, and drives the 8 user LEDs from the UI mode.
module input_conditioner_led #(
  parameter int DB_CYCLES = 1000000,
  parameter int LED_STEP  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_in,
  input  logic [3:0] btn_in,
  input  logic [3:0] state,
  output logic [7:0] sw_out,
  output logic [3:0] btn_pulse,
  output logic [7:0] led
);

  // Channels 0..7 are switches, 8..11 are buttons.
  localparam int NCH = 12;
  localparam int DBW = $clog2(DB_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam int LSW = (LED_STEP > 1) ? $clog2(LED_STEP) : 1;
  localparam logic [LSW-1:0] LED_LAST = LSW'(LED_STEP - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;
  logic [NCH-1:0] stable_q;
  logic [NCH-1:0] stable_d;
  logic [DBW-1:0] dbCnt_q [NCH];
  logic [DBW-1:0] dbCnt_d [NCH];
  logic [3:0]     pulse_q;
  logic [3:0]     pulse_d;

  logic [7:0]     led_q;
  logic [7:0]     led_d;
  logic [7:0]     pos_q;
  logic [7:0]     pos_d;
  logic [LSW-1:0] ledCnt_q;
  logic [LSW-1:0] ledCnt_d;

  assign raw = {btn_in, sw_in};

  // Debounce decision: a channel adopts its synced value only after it has
  // disagreed with the stable level for DB_CYCLES consecutive edges; any
  // agreement in between restarts the count. Button rises produce a pulse
  // on the same edge the stable level rises.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      dbCnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (dbCnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + DBW'(1);
        end
      end
    end
    pulse_d = stable_d[11:8] & ~stable_q[11:8];
  end

  // Synchronizer chain, debounce counters, stable levels and press pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < NCH; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
    end
  end

  // LED map and chaser advance. Any non-zero mode parks the chaser at bit 0
  // so re-entering mode 0 always starts from the first LED.
  always_comb begin
    led_d    = 8'h00;
    pos_d    = 8'h01;
    ledCnt_d = '0;
    if (state == 4'd0) begin
      led_d = pos_q;
      pos_d = pos_q;
      if (ledCnt_q == LED_LAST) begin
        pos_d = {pos_q[6:0], pos_q[7]};
      end else begin
        ledCnt_d = ledCnt_q + LSW'(1);
      end
    end else if (state <= 4'd7) begin
      led_d = 8'h01 << (state - 4'd1);
    end else if (state <= 4'd13) begin
      led_d = 8'h80 | (8'h01 << (state - 4'd8));
    end
  end

  // LED output register and chaser state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= 8'h00;
      pos_q    <= 8'h01;
      ledCnt_q <= '0;
    end else begin
      led_q    <= led_d;
      pos_q    <= pos_d;
      ledCnt_q <= ledCnt_d;
    end
  end

  assign sw_out    = stable_q[7:0];
  assign btn_pulse = pulse_q;
  assign led       = led_q;

endmodule

// File: tb/tb_input_conditioner_led.sv
// tb_input_conditioner_led: directed plus random stimulus for
// input_conditioner_led, compared every cycle against a behavioural model.
module tb_input_conditioner_led;

  localparam int DB   = 4;
  localparam int STEP = 3;

  // Expected LED pattern for modes 1..15 (entry 0 is the chaser, unused).
  localparam logic [7:0] LED_TABLE [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h00, 8'h00
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_in = '0;
  logic [3:0] btn_in = '0;
  logic [3:0] state = '0;
  logic [7:0] sw_out;
  logic [3:0] btn_pulse;
  logic [7:0] led;

  int checks = 0;
  int failures = 0;

  // Model: history of raw samples (index 0 = this edge), expected outputs.
  logic [11:0] hist [$];
  logic [11:0] expLevel;
  logic [3:0]  expPulse;
  logic [7:0]  expLed;
  int          chaseCount;

  input_conditioner_led #(
    .DB_CYCLES(DB),
    .LED_STEP (STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .btn_in   (btn_in),
    .state    (state),
    .sw_out   (sw_out),
    .btn_pulse(btn_pulse),
    .led      (led)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_front(12'h000);
    expLevel   = '0;
    expPulse   = '0;
    expLed     = '0;
    chaseCount = 0;
  endtask

  // A level flips once the DB most recent synchronised samples (raw delayed
  // two edges) all disagree with it. The chaser shows LED n/STEP mod 8 after
  // n edges spent in mode 0.
  task automatic modelEdge();
    logic [11:0] prev;
    bit          allDiffer;
    hist.push_front({btn_in, sw_in});
    while (hist.size() > DB + 2) void'(hist.pop_back());
    prev = expLevel;
    for (int ch = 0; ch < 12; ch++) begin
      allDiffer = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        if (hist[k][ch] == prev[ch]) allDiffer = 1'b0;
      end
      if (allDiffer) expLevel[ch] = ~prev[ch];
    end
    expPulse = expLevel[11:8] & ~prev[11:8];
    if (state == 4'd0) begin
      expLed = 8'h01 << ((chaseCount / STEP) % 8);
      chaseCount++;
    end else begin
      expLed = LED_TABLE[state];
      chaseCount = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] eSw,
                             input logic [3:0] eBtn, input logic [7:0] eLed);
    checks++;
    assert (sw_out === eSw) else begin
      failures++;
      $error("[TB] FAIL %s sw_out observed=%h expected=%h", tag, sw_out, eSw);
    end
    checks++;
    assert (btn_pulse === eBtn) else begin
      failures++;
      $error("[TB] FAIL %s btn_pulse observed=%b expected=%b", tag, btn_pulse, eBtn);
    end
    checks++;
    assert (led === eLed) else begin
      failures++;
      $error("[TB] FAIL %s led observed=%h expected=%h", tag, led, eLed);
    end
  endtask

  // Drive inputs (called at a falling edge), take one rising edge, check.
  task automatic applyStimulus(input logic [7:0] sw, input logic [3:0] btn,
                               input logic [3:0] st, input string tag);
    sw_in  = sw;
    btn_in = btn;
    state  = st;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag, expLevel[7:0], expPulse, expLed);
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic doReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    checkOutput(tag, 8'h00, 4'h0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [11:0] bits;
    logic [3:0]  st;

    $display("[TB] start");
    modelReset();
    @(negedge clk);
    checkOutput("reset", 8'h00, 4'h0, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Switch 0 step: level appears on the sixth edge.
    for (int i = 0; i < 8; i++) applyStimulus(8'h01, 4'h0, 4'd0, "sw_step");

    // Short glitch on switch 3 must be filtered.
    for (int i = 0; i < 3; i++) applyStimulus(8'h09, 4'h0, 4'd0, "sw_glitch");
    for (int i = 0; i < 8; i++) applyStimulus(8'h01, 4'h0, 4'd0, "sw_glitch_end");

    // Held button 2: one pulse, none on release.
    for (int i = 0; i < 20; i++) applyStimulus(8'h01, 4'b0100, 4'd0, "btn_hold");
    for (int i = 0; i < 10; i++) applyStimulus(8'h01, 4'b0000, 4'd0, "btn_release");

    // Chaser wraps, mode 3 interrupts, chaser restarts at bit 0.
    for (int i = 0; i < 30; i++) applyStimulus(8'h01, 4'h0, 4'd0, "chaser");
    for (int i = 0; i < 2; i++)  applyStimulus(8'h01, 4'h0, 4'd3, "mode3");
    for (int i = 0; i < 5; i++)  applyStimulus(8'h01, 4'h0, 4'd0, "chaser_restart");

    // Mode sweep 1..15.
    for (int s = 1; s < 16; s++) begin
      applyStimulus(8'h01, 4'h0, 4'(s), "sweep");
      applyStimulus(8'h01, 4'h0, 4'(s), "sweep");
    end

    // Reset mid-debounce with LED at 8'h08, button still held afterwards.
    applyStimulus(8'h01, 4'h0, 4'd4, "pre_abort");
    for (int i = 0; i < 4; i++) applyStimulus(8'h01, 4'b0010, 4'd4, "abort_arm");
    doReset("abort_reset");
    for (int i = 0; i < 12; i++) applyStimulus(8'h01, 4'b0010, 4'd4, "abort_hold");
    for (int i = 0; i < 8; i++)  applyStimulus(8'h01, 4'b0000, 4'd4, "abort_release");

    // Random phase: sparse bit flips so many inputs settle, random modes.
    bits = {btn_in, sw_in};
    st   = state;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) bits[$urandom_range(0, 11)] ^= 1'b1;
      if ($urandom_range(0, 24) == 0) begin
        st = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if (n == 750) doReset("random_reset");
      applyStimulus(bits[7:0], bits[11:8], st, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
